// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised next-PC selection with a circular
// return-address stack, overflow tracking and empty-return detection.
module pc_sequencer #(
    parameter int unsigned     WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h80),
    parameter int unsigned     INCR         = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           trap,
    input  logic                           branch_taken,
    input  logic [WIDTH-1:0]               branch_offset,
    input  logic                           jump,
    input  logic [WIDTH-1:0]               jump_target,
    input  logic                           call,
    input  logic                           ret,
    output logic [WIDTH-1:0]               pc_out,
    output logic [WIDTH-1:0]               pc_plus,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           ret_err,
    output logic                           ras_ovf
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_stack [RAS_DEPTH];
    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic             r_ret_err;
    logic             r_ovf;

    logic [WIDTH-1:0] w_pc_inc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [PTR_W-1:0] w_top_inc;
    logic [PTR_W-1:0] w_top_dec;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_replace;
    logic             w_ret_err;

    assign w_pc_inc  = r_pc + WIDTH'(INCR);
    assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
    assign w_empty   = (r_count == '0);
    // Stack pointer wraps modulo RAS_DEPTH, which need not be a power of two
    assign w_top_inc = (r_top == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_top + 1'b1;
    assign w_top_dec = (r_top == '0) ? PTR_W'(RAS_DEPTH - 1) : r_top - 1'b1;

    // Next-PC selection and stack operation, highest priority first
    always_comb begin
        w_pc_nxt  = w_pc_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_replace = 1'b0;
        w_ret_err = 1'b0;
        if (trap) begin
            w_pc_nxt = TRAP_VECTOR;
        end else if (stall) begin
            w_pc_nxt = r_pc;
        end else if (ret) begin
            if (!w_empty) begin
                w_pc_nxt  = r_stack[r_top];
                w_replace = jump && call;
                w_pop     = !(jump && call);
            end else begin
                w_pc_nxt  = w_pc_inc;
                w_ret_err = 1'b1;
                w_push    = jump && call;
            end
        end else if (jump) begin
            w_pc_nxt = jump_target;
            w_push   = call;
        end else if (branch_taken) begin
            w_pc_nxt = r_pc + branch_offset;
        end
    end

    // State update; a push while full lands on the oldest slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= RESET_VECTOR;
            r_top     <= '0;
            r_count   <= '0;
            r_ret_err <= 1'b0;
            r_ovf     <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_pc      <= w_pc_nxt;
            r_ret_err <= w_ret_err;
            if (w_push) begin
                r_stack[w_top_inc] <= w_pc_inc;
                r_top              <= w_top_inc;
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop) begin
                r_top   <= w_top_dec;
                r_count <= r_count - 1'b1;
            end else if (w_replace) begin
                r_stack[r_top] <= w_pc_inc;
            end
        end
    end

    assign pc_out    = r_pc;
    assign pc_plus   = r_pc + WIDTH'(INCR);
    assign ras_count = r_count;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ret_err   = r_ret_err;
    assign ras_ovf   = r_ovf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised scoreboard bench for pc_sequencer against a queue-based model.
module tb_pc_sequencer;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, trap = 1'b0, branch_taken = 1'b0;
    logic        jump = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] branch_offset = '0, jump_target = '0;
    logic [31:0] pc_out, pc_plus;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ret_err, ras_ovf;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        rerr;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ms[$];
    logic [31:0] mpc;
    logic        movf;
    int          checks = 0;
    int          failures = 0;

    pc_sequencer #(
        .WIDTH(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h80),
        .INCR(4), .RAS_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .trap(trap),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .jump(jump), .jump_target(jump_target), .call(call), .ret(ret),
        .pc_out(pc_out), .pc_plus(pc_plus), .ras_count(ras_count),
        .ras_empty(ras_empty), .ras_full(ras_full), .ret_err(ret_err),
        .ras_ovf(ras_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input logic [31:0] a);
        if (ms.size() == D) begin
            void'(ms.pop_front());
            movf = 1'b1;
        end
        ms.push_back(a);
    endtask

    // Drive one cycle of inputs at a falling edge and queue the expected result
    task automatic step(input logic tr, st, rt, jp, cl, br,
                        input logic [31:0] off, input logic [31:0] tgt);
        exp_t        e;
        logic        rerr;
        logic [31:0] inc;
        trap = tr; stall = st; ret = rt; jump = jp; call = cl;
        branch_taken = br; branch_offset = off; jump_target = tgt;
        rerr = 1'b0;
        inc  = mpc + 32'd4;
        if (tr) begin
            mpc = 32'h80;
        end else if (st) begin
            mpc = mpc;
        end else if (rt) begin
            if (ms.size() > 0) begin
                mpc = ms[ms.size()-1];
                if (jp && cl) ms[ms.size()-1] = inc;
                else void'(ms.pop_back());
            end else begin
                rerr = 1'b1;
                mpc  = inc;
                if (jp && cl) model_push(inc);
            end
        end else if (jp) begin
            if (cl) model_push(inc);
            mpc = tgt;
        end else if (br) begin
            mpc = mpc + off;
        end else begin
            mpc = inc;
        end
        e.pc   = mpc;
        e.cnt  = 3'(ms.size());
        e.rerr = rerr;
        e.ovf  = movf;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    // Monitor: every rising edge with a pending expectation is checked
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc_out",    pc_out,           e.pc);
            chk("pc_plus",   pc_plus,          e.pc + 32'd4);
            chk("ras_count", 32'(ras_count),   32'(e.cnt));
            chk("ras_empty", 32'(ras_empty),   32'(e.cnt == 3'd0));
            chk("ras_full",  32'(ras_full),    32'(e.cnt == 3'(D)));
            chk("ret_err",   32'(ret_err),     32'(e.rerr));
            chk("ras_ovf",   32'(ras_ovf),     32'(e.ovf));
        end
    end

    initial begin
        mpc  = 32'h0;
        movf = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pc",    pc_out,         32'h0);
        chk("rst_count", 32'(ras_count), 32'h0);
        chk("rst_empty", 32'(ras_empty), 32'h1);
        chk("rst_full",  32'(ras_full),  32'h0);
        chk("rst_rerr",  32'(ret_err),   32'h0);
        chk("rst_ovf",   32'(ras_ovf),   32'h0);
        rst = 1'b1;

        repeat (3) idle();
        step(0, 0, 0, 1, 0, 0, '0, 32'h10);
        step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, '0);
        step(0, 0, 0, 1, 0, 0, '0, 32'hFFFF_FFFC);
        idle();
        step(0, 0, 0, 1, 0, 0, '0, 32'h20);
        step(0, 0, 0, 1, 1, 0, '0, 32'h100);
        step(0, 0, 1, 0, 0, 0, '0, '0);

        for (int i = 0; i <= D; i++) step(0, 0, 0, 1, 1, 0, '0, 32'h1000 + 32'(i) * 32'h40);
        for (int i = 0; i < D; i++) step(0, 0, 1, 0, 0, 0, '0, '0);
        step(0, 0, 1, 0, 0, 0, '0, '0);

        step(0, 0, 0, 1, 1, 0, '0, 32'h200);
        step(0, 0, 0, 1, 1, 0, '0, 32'h300);
        step(1, 1, 1, 1, 0, 0, '0, 32'h400);
        step(0, 1, 0, 0, 0, 0, '0, '0);
        step(0, 1, 1, 1, 1, 1, 32'h8, 32'h500);
        step(0, 0, 1, 1, 1, 0, '0, 32'h600);

        for (int i = 0; i < 500; i++) begin
            step(($urandom % 16) == 0, ($urandom % 8) == 0, ($urandom % 4) == 0,
                 ($urandom % 4) == 0, ($urandom % 2) == 0, ($urandom % 3) == 0,
                 32'($signed(13'($urandom))) & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC);
        end

        for (int i = 0; i < D && ms.size() > 0; i++) step(0, 0, 1, 0, 0, 0, '0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0, '0, 32'h2000 + 32'(i) * 32'h10);
        chk("pre_async_count", 32'(ras_count), 32'd3);

        {trap, stall, ret, jump, call, branch_taken} = '0;
        #2 rst = 1'b0;
        #1;
        chk("async_pc",    pc_out,         32'h0);
        chk("async_count", 32'(ras_count), 32'h0);
        chk("async_empty", 32'(ras_empty), 32'h1);
        chk("async_ovf",   32'(ras_ovf),   32'h0);
        @(negedge clk);
        rst  = 1'b1;
        mpc  = 32'h0;
        movf = 1'b0;
        ms.delete();
        idle();
        idle();
        step(0, 0, 1, 0, 0, 0, '0, '0);

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: address width of every PC-related port.
REQ-002 SHALL provide parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-003 SHALL provide parameter TRAP_VECTOR, default 32'h80: PC target on trap.
REQ-004 SHALL provide parameter INCR, default 4: sequential increment.
REQ-005 SHALL provide parameter RAS_DEPTH, default 4, legal range 2..16: return-address stack entries.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port stall, input, 1: hold PC and stack.
REQ-009 SHALL have port trap, input, 1: redirect to TRAP_VECTOR.
REQ-010 SHALL have port branch_taken, input, 1: apply branch_offset.
REQ-011 SHALL have port branch_offset, input, WIDTH: signed two's-complement offset.
REQ-012 SHALL have port jump, input, 1: load jump_target.
REQ-013 SHALL have port jump_target, input, WIDTH: absolute target.
REQ-014 SHALL have port call, input, 1: qualifies jump; push return address.
REQ-015 SHALL have port ret, input, 1: pop stack into PC.
REQ-016 SHALL have port pc_out, output, WIDTH: registered current PC.
REQ-017 SHALL have port pc_plus, output, WIDTH: combinational pc_out+INCR.
REQ-018 SHALL have port ras_count, output, clog2(RAS_DEPTH+1): valid entry count.
REQ-019 SHALL have ports ras_empty and ras_full, output, 1 each: count==0 and count==RAS_DEPTH.
REQ-020 SHALL have port ret_err, output, 1: registered one-cycle pulse on ret with empty stack.
REQ-021 SHALL have port ras_ovf, output, 1: sticky flag, set on push while full.

Function
REQ-022 SHALL update all state on the rising edge of clk only; all arithmetic is modulo 2^WIDTH, with wrap-around permitted silently.
REQ-023 SHALL select next PC by fixed priority: trap, then stall, then ret, then jump, then branch_taken, then sequential (pc_out+INCR).
REQ-024 SHALL, on trap, load TRAP_VECTOR regardless of stall and leave the stack unchanged.
REQ-025 SHALL, on stall without trap, hold pc_out, stack, and ras_ovf, and drive ret_err low.
REQ-026 SHALL, on ret with count>0, load the top entry into pc_out and decrement count.
REQ-027 SHALL, on ret with count==0, load pc_out+INCR, pulse ret_err for one cycle, and leave count at 0.
REQ-028 SHALL, on jump, load jump_target; when call is also high, push pc_out+INCR.
REQ-029 SHALL, on push while full, overwrite the oldest entry (circular), keep count at RAS_DEPTH, and set ras_ovf.
REQ-030 SHALL, with ret, jump, and call high together, take the ret target and replace the top entry with pc_out+INCR, leaving count unchanged; with an empty stack, treat this case as REQ-027 plus a push.
REQ-031 SHALL ignore call without jump.
REQ-032 SHALL, on branch_taken, load pc_out+sign-extended branch_offset.
REQ-033 SHALL have a latency of one cycle from an input to pc_out; pc_plus follows pc_out combinationally.

Reset
REQ-034 SHALL, while rst is low, immediately force pc_out=RESET_VECTOR, ras_count=0, ras_empty=1, ras_full=0, ret_err=0, and ras_ovf=0, independent of clk.
REQ-035 SHALL discard stack contents on reset, including reset asserted mid-operation.
REQ-036 SHALL clear ras_ovf only by reset.
REQ-037 SHALL resume sequential fetch from RESET_VECTOR on the first rising edge after rst rises.

Verification
REQ-038 Reset and sequential: rst low, then 3 idle edges -> pc_out 0, 4, 8, 12.
REQ-039 Branch and wrap: pc=0x10 with branch_offset=-8 -> 0x08; pc=0xFFFFFFFC sequential -> 0x00000000.
REQ-040 Call/return: pc=0x20, jump+call to 0x100 -> pc 0x100 with count 1; ret -> pc 0x24 with count 0.
REQ-041 Overflow: RAS_DEPTH+1 calls with no stall -> ras_full=1, ras_ovf=1; RAS_DEPTH rets return the newest RAS_DEPTH addresses in LIFO order, then the next ret pulses ret_err.
REQ-042 Priority: trap+stall+ret+jump in the same cycle -> pc 0x80 with the stack unchanged; stall alone for 2 cycles -> pc and count held.
REQ-043 Async reset: rst pulsed low mid-cycle with count=3 -> pc_out=0 and count=0 before the next edge.
